// File: rtl/deep_comb_op_sequencer.sv
// deep_comb_op_sequencer
// Three-state command sequencer in front of an external combinational ALU.
// A command is registered onto alu_a/alu_b/alu_sel on acceptance, held for
// an optional multiply/divide settling delay, and the ALU output is then
// captured into a response register presented with a valid/ready handshake.
// The block performs no arithmetic of its own.

module deep_comb_op_sequencer #(
    parameter int MULDIV_WAIT = 2,
    parameter int COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_a,
    input  logic [7:0]         cmd_b,
    input  logic [3:0]         cmd_sel,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic [3:0]         alu_sel,
    input  logic [7:0]         alu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_data,
    output logic [3:0]         rsp_sel,
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    // Width of the settling counter; at least one bit even when no wait is configured.
    localparam int WAIT_W = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] SEL_MUL = 4'b1011;
    localparam logic [3:0] SEL_DIV = 4'b0011;

    logic [1:0]         state_q,    state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]         alu_a_q,    alu_a_d;
    logic [7:0]         alu_b_q,    alu_b_d;
    logic [3:0]         alu_sel_q,  alu_sel_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic [3:0]         rsp_sel_q,  rsp_sel_d;
    logic [COUNT_W-1:0] op_count_q, op_count_d;

    logic accept;
    logic exec_done;
    logic rsp_fire;
    logic cmd_is_muldiv;

    // Handshake and phase qualifiers shared by every register update.
    always_comb begin
        accept        = (state_q == ST_IDLE) && cmd_valid;
        exec_done     = (state_q == ST_EXEC) && (wait_cnt_q == '0);
        rsp_fire      = (state_q == ST_RESP) && rsp_ready;
        cmd_is_muldiv = (cmd_sel == SEL_MUL) || (cmd_sel == SEL_DIV);
    end

    // Next-state: IDLE -> EXEC on acceptance, EXEC -> RESP once settled, RESP -> IDLE on consumer ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Settling counter: loaded at acceptance so it is valid on EXEC entry, then counts down.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (accept) begin
            wait_cnt_d = cmd_is_muldiv ? WAIT_W'(MULDIV_WAIT) : '0;
        end else if ((state_q == ST_EXEC) && (wait_cnt_q != '0)) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
        end
    end

    // ALU operand/select registers change only when a command is accepted.
    always_comb begin
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        if (accept) begin
            alu_a_d   = cmd_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_sel;
        end
    end

    // Response registers capture the ALU output unmodified at the end of EXEC and hold through RESP.
    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_sel_d  = rsp_sel_q;
        if (exec_done) begin
            rsp_data_d = alu_result;
            rsp_sel_d  = alu_sel_q;
        end
    end

    // Completed-response counter, wraps naturally at all-ones.
    always_comb begin
        op_count_d = op_count_q;
        if (rsp_fire) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    // State registers with synchronous reset taking priority over all handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rsp_data_q <= '0;
            rsp_sel_q  <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_sel_q  <= rsp_sel_d;
            op_count_q <= op_count_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_sel   = rsp_sel_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_deep_comb_op_sequencer.sv
// Testbench for deep_comb_op_sequencer: directed scenarios followed by
// randomized commands, checked by a negedge monitor against a queue of
// expected responses pushed by the command driver.

module tb_deep_comb_op_sequencer;

    localparam int MULDIV_WAIT = 2;
    localparam int COUNT_W     = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_a;
    logic [7:0]         cmd_b;
    logic [3:0]         cmd_sel;
    logic [7:0]         alu_a;
    logic [7:0]         alu_b;
    logic [3:0]         alu_sel;
    logic [7:0]         alu_result;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [7:0]         rsp_data;
    logic [3:0]         rsp_sel;
    logic               busy;
    logic [COUNT_W-1:0] op_count;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  sel;
        logic [7:0]  data;
        int unsigned due;
        int          gap;
        int          exp_gap;
    } item_t;

    item_t        exp_q[$];
    item_t        cur;
    bit           cur_active = 1'b0;
    bit           pend       = 1'b0;
    bit           rst_prev   = 1'b0;
    logic [COUNT_W-1:0] exp_cnt = '0;
    int unsigned  cyc        = 0;
    int unsigned  last_acc   = 0;
    int           vectors    = 0;
    int           miscompares = 0;
    bit           rr_random  = 1'b0;
    bit           rr_level   = 1'b1;
    bit           done_req   = 1'b0;
    bit           done_ack   = 1'b0;

    deep_comb_op_sequencer #(
        .MULDIV_WAIT (MULDIV_WAIT),
        .COUNT_W     (COUNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_sel    (rsp_sel),
        .busy       (busy),
        .op_count   (op_count)
    );

    // Downstream ALU stand-in: add, multiply, divide, xor, plus a few fillers.
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] sel);
        case (sel)
            4'b1111: return a + b;
            4'b1011: return 8'((16'(a) * 16'(b)) & 16'h00FF);
            4'b0011: return (b == 8'd0) ? 8'hFF : a / b;
            4'b1001: return a ^ b;
            4'b0001: return a & b;
            4'b0010: return a | b;
            4'b0100: return a - b;
            default: return ~a + {4'h0, sel};
        endcase
    endfunction

    function automatic int unsigned wait_of(input logic [3:0] sel);
        return (sel == 4'b1011 || sel == 4'b0011) ? MULDIV_WAIT : 0;
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_sel);

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready: either a fixed level or random ~75% ready.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rr_random) rsp_ready = ($urandom_range(0, 3) != 0);
            else           rsp_ready = rr_level;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge clk) begin
        bit busy_exp;
        item_t front;
        if (rst_prev) begin
            chk("reset_rsp_valid", rsp_valid, 0);
            chk("reset_busy",      busy,      0);
            chk("reset_cmd_ready", cmd_ready, 1);
            chk("reset_alu_a",     alu_a,     0);
            chk("reset_alu_b",     alu_b,     0);
            chk("reset_alu_sel",   alu_sel,   0);
            chk("reset_rsp_data",  rsp_data,  0);
            chk("reset_rsp_sel",   rsp_sel,   0);
            chk("reset_op_count",  op_count,  0);
        end
        if (pend) begin
            pend       = 1'b0;
            cur_active = 1'b0;
            exp_cnt    = exp_cnt + 1'b1;
            chk("op_count", op_count, exp_cnt);
        end
        if (rst) begin
            exp_q.delete();
            cur_active = 1'b0;
            exp_cnt    = '0;
            rst_prev   = 1'b1;
        end else begin
            rst_prev = 1'b0;
            busy_exp = cur_active || (exp_q.size() > 0);
            chk("busy",      busy,      busy_exp);
            chk("cmd_ready", cmd_ready, !busy_exp);
            if (busy_exp) begin
                front = cur_active ? cur : exp_q[0];
                chk("alu_a_hold",   alu_a,   front.a);
                chk("alu_b_hold",   alu_b,   front.b);
                chk("alu_sel_hold", alu_sel, front.sel);
            end
            if (!cur_active && exp_q.size() > 0 && (rsp_valid || cyc >= exp_q[0].due)) begin
                cur = exp_q.pop_front();
                chk("rsp_latency",  cyc,       cur.due);
                chk("rsp_valid_at_due", rsp_valid, 1);
                if (cur.exp_gap >= 0) chk("accept_interval", cur.gap, cur.exp_gap);
                if (rsp_valid) begin
                    cur_active = 1'b1;
                    chk("rsp_data", rsp_data, cur.data);
                    chk("rsp_sel",  rsp_sel,  cur.sel);
                end
            end else if (cur_active) begin
                chk("rsp_valid_hold", rsp_valid, 1);
                chk("rsp_data_hold",  rsp_data,  cur.data);
                chk("rsp_sel_hold",   rsp_sel,   cur.sel);
            end else if (rsp_valid) begin
                chk("unexpected_rsp", rsp_valid, 0);
            end
            if (cur_active && rsp_valid && rsp_ready) pend = 1'b1;
        end
        if (done_req && !done_ack) begin
            chk("drain_outstanding", exp_q.size() + (cur_active ? 1 : 0), 0);
            done_ack = 1'b1;
        end
    end

    // Offer a command until accepted; queue the expected response once the acceptance edge passes.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        input int exp_gap);
        item_t it;
        bit accepted;
        int unsigned k;
        accepted  = 1'b0;
        k         = 0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clk);
            if (cmd_ready && !rst) begin
                accepted = 1'b1;
                k        = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            $display("FAIL cmd_accept_timeout: got no acceptance expected acceptance within 200 cycles");
            $fatal(1);
        end
        it.a       = a;
        it.b       = b;
        it.sel     = sel;
        it.data    = alu_model(a, b, sel);
        it.due     = k + 2 + wait_of(sel);
        it.gap     = int'(k - last_acc);
        it.exp_gap = exp_gap;
        last_acc   = k;
        exp_q.push_back(it);
        cmd_valid  = 1'b0;
        cmd_a      = 8'($urandom);
        cmd_b      = 8'($urandom);
        cmd_sel    = 4'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Add and multiply reference cases
        send(8'h10, 8'h05, 4'b1111, -1);
        idle(4);
        send(8'd3, 8'd4, 4'b1011, -1);
        idle(6);

        // Backpressure with a second command offered while busy
        rr_level = 1'b0;
        idle(2);
        send(8'h21, 8'h07, 4'b1001, -1);
        fork
            send(8'h55, 8'h0F, 4'b0100, -1);
            begin
                idle(8);
                rr_level = 1'b1;
            end
        join
        idle(4);

        // Back-to-back XOR with consumer always ready
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), 8'($urandom), 4'b1001, (i == 0) ? -1 : 3);
        end
        idle(4);

        // Reset in the middle of a divide (settling counter at 1)
        send(8'd100, 8'd7, 4'b0011, -1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // Random traffic, long enough to wrap op_count
        rr_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            idle($urandom_range(0, 2));
            send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), -1);
        end
        rr_random = 1'b0;
        rr_level  = 1'b1;
        idle(20);

        done_req = 1'b1;
        for (int n = 0; n < 10 && !done_ack; n++) idle(1);
        if (!done_ack) begin
            $display("FAIL drain_handshake: got no monitor acknowledge expected acknowledge");
            $fatal(1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deep_comb_op_sequencer.md
DEEP_COMB_OP_SEQUENCER -- requirements
Module: deep_comb_op_sequencer

Interface
REQ-001 Parameter MULDIV_WAIT, default 2, SHALL set the extra EXEC cycles for multiply (sel 4'b1011) and divide (sel 4'b0011).
REQ-002 Parameter COUNT_W, default 8, SHALL set the width of op_count.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 cmd_valid  input  1  SHALL flag that a command is offered.
REQ-006 cmd_ready  output  1  SHALL flag that the block accepts a command this cycle.
REQ-007 cmd_a, cmd_b  input  8 each  SHALL carry the command operands.
REQ-008 cmd_sel  input  4  SHALL carry the command 4-bit operation select.
REQ-009 alu_a, alu_b  output  8 each  SHALL drive the registered operands to the downstream combinational ALU.
REQ-010 alu_sel  output  4  SHALL drive the registered select to the ALU.
REQ-011 alu_result  input  8  SHALL carry the combinational ALU result.
REQ-012 rsp_valid  output  1  SHALL flag that a result is presented.
REQ-013 rsp_ready  input  1  SHALL flag that the consumer accepts the result.
REQ-014 rsp_data  output  8  SHALL carry the captured result.
REQ-015 rsp_sel  output  4  SHALL echo the select that produced rsp_data.
REQ-016 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-017 op_count  output  COUNT_W  SHALL count completed response handshakes.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-020 In IDLE, when cmd_valid=1, the block SHALL latch cmd_a/cmd_b/cmd_sel into alu_a/alu_b/alu_sel and go to EXEC.
REQ-021 On entry to EXEC, wait_cnt SHALL load MULDIV_WAIT for sel 4'b1011 or 4'b0011, else 0.
REQ-022 In EXEC with wait_cnt=0, the block SHALL capture alu_result into rsp_data and alu_sel into rsp_sel, then go to RESP.
REQ-023 In EXEC with wait_cnt>0, the block SHALL decrement wait_cnt and stay in EXEC.
REQ-024 In RESP, when rsp_ready=1, the block SHALL go to IDLE and increment op_count, wrapping from all-ones to 0.
REQ-025 When rsp_ready=0, RESP SHALL hold with rsp_data/rsp_sel stable.
REQ-026 alu_a/alu_b/alu_sel SHALL change only on command acceptance and SHALL stay stable through EXEC and RESP.
REQ-027 Latency: acceptance edge E0, rsp_valid high from edge E1+W, where W = wait_cnt load value.
REQ-028 Throughput with rsp_ready held high: one command per 3+W cycles; no command is accepted in the RESP-exit cycle.
REQ-029 A command offered while busy SHALL NOT be accepted, and SHALL have no effect on state.
REQ-030 rsp_data SHALL pass alu_result unmodified; the block SHALL NOT compute any arithmetic itself.

Reset
REQ-031 When rst=1 at an edge, the FSM SHALL enter IDLE from any state, including mid-EXEC or mid-RESP.
REQ-032 On reset, the following SHALL clear to 0: alu_a, alu_b, alu_sel, rsp_data, rsp_sel, wait_cnt and op_count.
REQ-033 During and after reset, rsp_valid=0, busy=0 and cmd_ready=1.
REQ-034 An operation interrupted by reset SHALL be discarded without a response.
REQ-035 rst SHALL take priority over every handshake in the same cycle.

Verification
REQ-036 Add: sel=4'b1111, a=8'h10, b=8'h05, bench ALU model returns a+b -> rsp_data=8'h15, rsp_sel=4'b1111 at E1; op_count 0->1 after rsp_ready.
REQ-037 Multiply: sel=4'b1011, a=3, b=4, MULDIV_WAIT=2 -> rsp_valid first high at E3 with rsp_data=8'h0C; cmd_ready=0 for E1..E3.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles while cmd_valid=1 -> rsp_data/alu_* stable, no second acceptance, busy=1; release -> IDLE next cycle.
REQ-039 Wrap: 256 completed ops with COUNT_W=8 -> op_count goes 8'hFF -> 8'h00.
REQ-040 Reset mid-EXEC (divide, wait_cnt=1) -> next cycle IDLE, rsp_valid=0, alu_sel=0, op_count=0, no response emitted.
REQ-041 Back-to-back XOR (sel 4'b1001) with rsp_ready=1 -> acceptances every 3 cycles, each rsp_data equal to a^b.
